// File: rtl/iob2wishbone.sv
// -----------------------------------------------------------------------------
// iob2wishbone
//
// Bridges a single-outstanding IOb responder interface onto a Wishbone
// initiator. Each IOb request is registered, presented on Wishbone until the
// slave terminates it, and answered with a one-cycle ready_o pulse.
//
// Ports
//   clk_i, arst_i          clock, asynchronous active-high reset
//   valid_i                IOb request strobe
//   address_i, wdata_i     IOb address and write data
//   wstrb_i                IOb byte strobes (all zero means read)
//   rdata_o                IOb read data, holds between transfers
//   ready_o                IOb completion pulse (one cycle)
//   err_o                  IOb error flag, meaningful only with ready_o
//   wb_addr_o, wb_data_o   Wishbone address and write data
//   wb_select_o, wb_we_o   Wishbone byte select and write enable
//   wb_cyc_o, wb_stb_o     Wishbone cycle and strobe
//   wb_data_i              Wishbone read data
//   wb_ack_i, wb_error_i   Wishbone cycle terminations
//
// Configuration
//   IOB2WB_TIMEOUT_EN      when defined, a bus watchdog ends a Wishbone cycle
//                          as an error after TIMEOUT_CYC cycles without any
//                          termination; when undefined the bridge waits
//                          indefinitely and carries no counter.
// -----------------------------------------------------------------------------
module iob2wishbone #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                valid_i,
  input  logic [ADDR_W-1:0]   address_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                ready_o,
  output logic                err_o,
  output logic [ADDR_W-1:0]   wb_addr_o,
  output logic [DATA_W/8-1:0] wb_select_o,
  output logic                wb_we_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic [DATA_W-1:0]   wb_data_o,
  input  logic [DATA_W-1:0]   wb_data_i,
  input  logic                wb_ack_i,
  input  logic                wb_error_i
);

  localparam int SEL_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [SEL_W-1:0]  sel_q;
  logic              we_q;
  logic              cyc_q;
  logic              ready_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic              isWrite;
  logic [SEL_W-1:0]  sel_d;
  logic              timeoutHit;
  logic              endByAck;
  logic              endByErr;

  // A request with any strobe set is a write and selects exactly those bytes;
  // a read always selects the full word.
  assign isWrite = |wstrb_i;
  assign sel_d   = isWrite ? wstrb_i : '1;

`ifdef IOB2WB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] tmoCnt_q;
  logic [CNT_W-1:0] tmoCnt_d;

  // The counter sits at zero outside BUS, so every entry into BUS (from IDLE
  // or straight from RESP) starts counting from zero.
  always_comb begin
    tmoCnt_d = '0;
    if (state_q == BUS) begin
      tmoCnt_d = tmoCnt_q + CNT_W'(1);
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      tmoCnt_q <= '0;
    end else begin
      tmoCnt_q <= tmoCnt_d;
    end
  end

  // The last BUS cycle of the allowed window: counter value TIMEOUT_CYC-1.
  assign timeoutHit = (state_q == BUS) && (tmoCnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic unusedTimeoutCfg;

  // No watchdog in this build; TIMEOUT_CYC has no effect and is tied off.
  assign timeoutHit       = 1'b0;
  assign unusedTimeoutCfg = (TIMEOUT_CYC != 0);
`endif

  // Ack and error together count as error; a timeout only applies when the
  // slave gave no termination at all, so an ack in the limit cycle wins.
  assign endByAck = wb_ack_i & ~wb_error_i;
  assign endByErr = wb_error_i | (~wb_ack_i & timeoutHit);

  // Main bridge FSM. Every output comes straight from a register here; the
  // asynchronous reset drops cyc/stb at once and discards any cycle in flight.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE, RESP: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          if (valid_i) begin
            addr_q  <= address_i;
            wdata_q <= wdata_i;
            sel_q   <= sel_d;
            we_q    <= isWrite;
            cyc_q   <= 1'b1;
            state_q <= BUS;
          end else begin
            state_q <= IDLE;
          end
        end
        BUS: begin
          if (endByAck || endByErr) begin
            cyc_q   <= 1'b0;
            ready_q <= 1'b1;
            err_q   <= endByErr;
            if (!we_q) begin
              rdata_q <= endByErr ? '0 : wb_data_i;
            end
            state_q <= RESP;
          end
        end
        default: begin
          cyc_q   <= 1'b0;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign wb_addr_o   = addr_q;
  assign wb_data_o   = wdata_q;
  assign wb_select_o = sel_q;
  assign wb_we_o     = we_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign ready_o     = ready_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_iob2wishbone.sv
// -----------------------------------------------------------------------------
// tb_iob2wishbone
//
// Directed bench for iob2wishbone: a table of single transfers with
// hand-computed expectations, followed by hand-written sequences for
// back-to-back transfers, the bus watchdog (or its absence) and reset
// during an active Wishbone cycle.
// -----------------------------------------------------------------------------
module tb_iob2wishbone;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic          clock = 1'b0;
   logic          reset;
   logic          validIn;
   logic [AW-1:0] addressIn;
   logic [DW-1:0] wdataIn;
   logic [SW-1:0] wstrbIn;
   logic [DW-1:0] rdataOut;
   logic          readyOut;
   logic          errOut;
   logic [AW-1:0] wbAddr;
   logic [SW-1:0] wbSelect;
   logic          wbWe;
   logic          wbCyc;
   logic          wbStb;
   logic [DW-1:0] wbDataOut;
   logic [DW-1:0] wbDataIn;
   logic          wbAck;
   logic          wbError;

   int nChecks = 0;
   int nFail   = 0;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] wstrb;
      int            waitCyc;
      logic          ack;
      logic          err;
      logic [DW-1:0] busData;
      logic          expWe;
      logic [SW-1:0] expSel;
      logic          expErr;
      logic [DW-1:0] expRdata;
   } vec_t;

   vec_t vecs[7];

   iob2wishbone #(
      .ADDR_W(AW),
      .DATA_W(DW),
      .TIMEOUT_CYC(8)
   ) dut (
      .clk_i(clock),
      .arst_i(reset),
      .valid_i(validIn),
      .address_i(addressIn),
      .wdata_i(wdataIn),
      .wstrb_i(wstrbIn),
      .rdata_o(rdataOut),
      .ready_o(readyOut),
      .err_o(errOut),
      .wb_addr_o(wbAddr),
      .wb_select_o(wbSelect),
      .wb_we_o(wbWe),
      .wb_cyc_o(wbCyc),
      .wb_stb_o(wbStb),
      .wb_data_o(wbDataOut),
      .wb_data_i(wbDataIn),
      .wb_ack_i(wbAck),
      .wb_error_i(wbError)
   );

   // Free-running 10-unit clock.
   always #5 clock = ~clock;

   // Compare one observed value against its expected value and log a miss.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Present one IOb request on the responder inputs.
   task automatic applyStimulus(input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                input logic [SW-1:0] wstrb);
      validIn   = 1'b1;
      addressIn = addr;
      wdataIn   = wdata;
      wstrbIn   = wstrb;
   endtask

   // Step to just after the next rising edge, where outputs are sampled.
   task automatic stepCycle();
      @(posedge clock);
      #1;
   endtask

   // Run one table entry: request, hold BUS for waitCyc cycles, terminate,
   // then check the response cycle and the return to idle.
   task automatic runVector(input int idx, input vec_t v);
      applyStimulus(v.addr, v.wdata, v.wstrb);
      stepCycle();
      validIn   = 1'b1;
      addressIn = 32'hFFFF_FFF0;
      wdataIn   = 32'h0;
      wstrbIn   = 4'h0;
      checkOutput($sformatf("v%0d.cyc", idx), wbCyc, 1'b1);
      checkOutput($sformatf("v%0d.stb", idx), wbStb, 1'b1);
      checkOutput($sformatf("v%0d.we", idx), wbWe, v.expWe);
      checkOutput($sformatf("v%0d.sel", idx), wbSelect, v.expSel);
      checkOutput($sformatf("v%0d.addr", idx), wbAddr, v.addr);
      checkOutput($sformatf("v%0d.wdata", idx), wbDataOut, v.wdata);
      for (int i = 0; i < v.waitCyc; i++) begin
         stepCycle();
         checkOutput($sformatf("v%0d.waitCyc%0d", idx, i), {wbCyc, readyOut}, 2'b10);
         checkOutput($sformatf("v%0d.addrHeld%0d", idx, i), wbAddr, v.addr);
      end
      validIn  = 1'b0;
      wbAck    = v.ack;
      wbError  = v.err;
      wbDataIn = v.busData;
      stepCycle();
      wbAck    = 1'b0;
      wbError  = 1'b0;
      wbDataIn = 32'h5A5A_5A5A;
      checkOutput($sformatf("v%0d.ready", idx), readyOut, 1'b1);
      checkOutput($sformatf("v%0d.err", idx), errOut, v.expErr);
      checkOutput($sformatf("v%0d.cycDone", idx), {wbCyc, wbStb}, 2'b00);
      checkOutput($sformatf("v%0d.rdata", idx), rdataOut, v.expRdata);
      stepCycle();
      checkOutput($sformatf("v%0d.readyPulse", idx), {readyOut, errOut, wbCyc}, 3'b000);
   endtask

   // Main stimulus sequence.
   initial begin
      int cycHigh;

      vecs[0] = '{32'h40, 32'hDEAD_BEEF, 4'hF, 3, 1'b1, 1'b0, 32'h0,         1'b1, 4'hF, 1'b0, 32'h0};
      vecs[1] = '{32'h44, 32'h0,         4'h0, 0, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 4'hF, 1'b0, 32'h1234_5678};
      vecs[2] = '{32'h48, 32'h0,         4'h0, 0, 1'b0, 1'b1, 32'hAAAA_5555, 1'b0, 4'hF, 1'b1, 32'h0};
      vecs[3] = '{32'h4C, 32'h0,         4'h0, 1, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b0, 4'hF, 1'b0, 32'hCAFE_F00D};
      vecs[4] = '{32'h50, 32'h0102_0304, 4'h5, 2, 1'b0, 1'b1, 32'h7777_7777, 1'b1, 4'h5, 1'b1, 32'hCAFE_F00D};
      vecs[5] = '{32'h54, 32'h0,         4'h0, 0, 1'b1, 1'b1, 32'h3333_3333, 1'b0, 4'hF, 1'b1, 32'h0};
      vecs[6] = '{32'h58, 32'hFEED_0001, 4'h8, 0, 1'b1, 1'b0, 32'h4444_4444, 1'b1, 4'h8, 1'b0, 32'h0};

      reset     = 1'b1;
      validIn   = 1'b0;
      addressIn = '0;
      wdataIn   = '0;
      wstrbIn   = '0;
      wbDataIn  = '0;
      wbAck     = 1'b0;
      wbError   = 1'b0;

      stepCycle();
      stepCycle();
      checkOutput("reset.ctrl", {wbCyc, wbStb, wbWe, readyOut, errOut}, 5'b00000);
      checkOutput("reset.addr", wbAddr, 32'h0);
      checkOutput("reset.sel", wbSelect, 4'h0);
      checkOutput("reset.wdata", wbDataOut, 32'h0);
      checkOutput("reset.rdata", rdataOut, 32'h0);
      reset = 1'b0;
      stepCycle();
      checkOutput("idle.ctrl", {wbCyc, readyOut}, 2'b00);

      for (int i = 0; i < 7; i++) begin
         runVector(i, vecs[i]);
      end

      $display("[TB] back-to-back transfers");
      applyStimulus(32'h60, 32'h0, 4'h0);
      stepCycle();
      validIn  = 1'b0;
      wbAck    = 1'b1;
      wbDataIn = 32'h1111_2222;
      stepCycle();
      checkOutput("b2b.ready1", readyOut, 1'b1);
      checkOutput("b2b.rdata1", rdataOut, 32'h1111_2222);
      wbAck = 1'b0;
      applyStimulus(32'h64, 32'h0BAD_CAFE, 4'h3);
      stepCycle();
      validIn = 1'b0;
      checkOutput("b2b.cyc2", {wbCyc, wbStb, readyOut}, 3'b110);
      checkOutput("b2b.addr2", wbAddr, 32'h64);
      checkOutput("b2b.sel2", {wbWe, wbSelect}, 5'b1_0011);
      checkOutput("b2b.wdata2", wbDataOut, 32'h0BAD_CAFE);
      wbAck = 1'b1;
      stepCycle();
      wbAck = 1'b0;
      checkOutput("b2b.ready2", {readyOut, errOut, wbCyc}, 3'b100);
      checkOutput("b2b.rdata2", rdataOut, 32'h1111_2222);
      stepCycle();
      checkOutput("b2b.idle", {readyOut, wbCyc}, 2'b00);

`ifdef IOB2WB_TIMEOUT_EN
      $display("[TB] watchdog timeout");
      applyStimulus(32'h70, 32'h0, 4'h0);
      cycHigh = 0;
      for (int c = 1; c <= 8; c++) begin
         stepCycle();
         validIn = 1'b0;
         if (wbCyc === 1'b1 && readyOut === 1'b0) cycHigh++;
      end
      checkOutput("tmo.cycHeld", cycHigh, 8);
      stepCycle();
      checkOutput("tmo.resp", {wbCyc, readyOut, errOut}, 3'b011);
      checkOutput("tmo.rdata", rdataOut, 32'h0);
      stepCycle();

      $display("[TB] ack in the limit cycle");
      applyStimulus(32'h74, 32'h0, 4'h0);
      for (int c = 1; c <= 8; c++) begin
         stepCycle();
         validIn = 1'b0;
      end
      wbAck    = 1'b1;
      wbDataIn = 32'h6666_1234;
      stepCycle();
      wbAck = 1'b0;
      checkOutput("tmoAck.resp", {wbCyc, readyOut, errOut}, 3'b010);
      checkOutput("tmoAck.rdata", rdataOut, 32'h6666_1234);
      stepCycle();
`else
      $display("[TB] no watchdog: cycle held");
      applyStimulus(32'h70, 32'h0, 4'h0);
      cycHigh = 0;
      for (int c = 1; c <= 1000; c++) begin
         stepCycle();
         validIn = 1'b0;
         if (wbCyc === 1'b1 && readyOut === 1'b0) cycHigh++;
      end
      checkOutput("noTmo.cycHeld", cycHigh, 1000);
      wbAck    = 1'b1;
      wbDataIn = 32'h7777_8888;
      stepCycle();
      wbAck = 1'b0;
      checkOutput("noTmo.resp", {wbCyc, readyOut, errOut}, 3'b010);
      checkOutput("noTmo.rdata", rdataOut, 32'h7777_8888);
      stepCycle();
`endif

      $display("[TB] reset during BUS");
      applyStimulus(32'h80, 32'h1357_9BDF, 4'hF);
      stepCycle();
      validIn = 1'b0;
      checkOutput("rst.cycBefore", wbCyc, 1'b1);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("rst.cycAsync", {wbCyc, wbStb, wbWe}, 3'b000);
      checkOutput("rst.addr", wbAddr, 32'h0);
      #1;
      reset = 1'b0;
      wbAck = 1'b1;
      stepCycle();
      wbAck = 1'b0;
      checkOutput("rst.noReady", {readyOut, wbCyc}, 2'b00);
      stepCycle();
      checkOutput("rst.noReady2", readyOut, 1'b0);
      applyStimulus(32'h84, 32'h0, 4'h0);
      stepCycle();
      validIn = 1'b0;
      checkOutput("rst.nextAddr", {wbCyc, wbAddr}, {1'b1, 32'h84});
      wbAck    = 1'b1;
      wbDataIn = 32'h9999_AAAA;
      stepCycle();
      wbAck = 1'b0;
      checkOutput("rst.nextResp", {readyOut, errOut}, 2'b10);
      checkOutput("rst.nextRdata", rdataOut, 32'h9999_AAAA);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/iob2wishbone.md
IOB2WISHBONE -- requirements
Module: iob2wishbone

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width on both sides.
REQ-002 SHALL have parameter DATA_W, default 32, data width on both sides; DATA_W/8 byte strobes.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, bus-watchdog limit in clk_i cycles; used only under IOB2WB_TIMEOUT_EN.
REQ-004 SHALL have one clock and an asynchronous active-high reset: clk_i  in  1  clock; arst_i  in  1  asynchronous active-high reset.
REQ-005 SHALL have these IOb responder ports: valid_i  in  1  request strobe; address_i  in  ADDR_W  address; wdata_i  in  DATA_W  write data; wstrb_i  in  DATA_W/8  byte strobes, zero means read; rdata_o  out  DATA_W  read data; ready_o  out  1  completion pulse.
REQ-006 SHALL have err_o  out  1  error flag, valid only with ready_o.
REQ-007 SHALL have these Wishbone initiator ports: wb_addr_o  out  ADDR_W; wb_select_o  out  DATA_W/8; wb_we_o  out  1; wb_cyc_o  out  1; wb_stb_o  out  1; wb_data_o  out  DATA_W; wb_data_i  in  DATA_W; wb_ack_i  in  1; wb_error_i  in  1.

Function
REQ-008 SHALL implement the FSM IDLE -> BUS -> RESP; all outputs registered.
REQ-009 SHALL, in IDLE or RESP with valid_i=1, capture address_i, wdata_i and wstrb_i, and enter BUS on the next edge.
REQ-010 SHALL ignore valid_i while in BUS; no queueing.
REQ-011 SHALL, in BUS, hold wb_cyc_o=wb_stb_o=1 with wb_addr_o and wb_data_o stable at the captured values.
REQ-012 SHALL drive wb_we_o=1 and wb_select_o=wstrb for a write (wstrb!=0), and wb_we_o=0 with wb_select_o all ones for a read.
REQ-013 SHALL end the cycle on the first edge in BUS where wb_ack_i or wb_error_i is 1, then enter RESP with wb_cyc_o=wb_stb_o=0.
REQ-014 SHALL treat wb_ack_i and wb_error_i both high in the same cycle as an error.
REQ-015 SHALL hold ready_o=1 for exactly the single RESP cycle, and 0 otherwise.
REQ-016 SHALL set err_o=1 in RESP if the cycle ended by error (or timeout), and 0 otherwise.
REQ-017 SHALL, on a read ending by ack, load rdata_o from wb_data_i; on a read ending by error, load 0; on a write, leave rdata_o unchanged; rdata_o holds between transfers.
REQ-018 SHALL give latency valid_i edge n -> cyc/stb high n+1 -> termination sampled at edge k -> ready_o high k+1; minimum request-to-ready is 2 cycles.
REQ-019 SHALL go from RESP to BUS when valid_i=1, and to IDLE otherwise (back-to-back with no idle bubble).

Reset
REQ-020 SHALL, while arst_i=1, force state IDLE and clear wb_cyc_o, wb_stb_o, wb_we_o, ready_o, err_o and all address, data, select and rdata registers to 0.
REQ-021 SHALL, on reset during BUS, abort the cycle (cyc/stb low immediately, asynchronously) and produce no ready_o for it.

Configuration
REQ-022 SHALL, when IOB2WB_TIMEOUT_EN is defined, count cycles in BUS from 0 and, if neither wb_ack_i nor wb_error_i arrives after TIMEOUT_CYC cycles, end the cycle as an error (REQ-016/017 apply).
REQ-023 SHALL clear the counter on entry to BUS; an ack in the limit cycle wins over the timeout.
REQ-024 SHALL, when IOB2WB_TIMEOUT_EN is undefined, contain no counter and wait in BUS indefinitely.

Verification
REQ-025 SHALL cover a write: valid_i, address_i=0x40, wdata_i=0xDEADBEEF, wstrb_i=0xF, ack after 3 cycles -> wb_we_o=1, select=0xF, ready_o one cycle, err_o=0.
REQ-026 SHALL cover a read: valid_i, address_i=0x44, wstrb_i=0, ack with wb_data_i=0x12345678 at the first BUS cycle -> ready_o 2 cycles after valid_i, rdata_o=0x12345678.
REQ-027 SHALL cover a read error: wb_error_i=1 -> ready_o=1, err_o=1, rdata_o=0.
REQ-028 SHALL cover back-to-back transfers: valid_i high in the RESP cycle -> cyc/stb reasserted on the next cycle, second transfer completes correctly.
REQ-029 SHALL cover the timeout with IOB2WB_TIMEOUT_EN and TIMEOUT_CYC=8: no ack -> cyc low and ready_o=err_o=1 at BUS cycle 9; without the macro, cyc stays high for 1000 cycles.
REQ-030 SHALL cover reset mid-BUS: arst_i pulse -> wb_cyc_o=0 immediately, no ready_o, next request works.
